zero_arith_exec: RTL and testbench

- Clocked, parametrised executor for generated Zero test programs; successor to the single-shot combinational test harness.
- Fetches instructions from an external synchronous instruction ROM and executes ADD/SUB/MOV/OUT/HALT against a local register memory.
- OUT pushes results into a back-pressured output FIFO.
- Reports finished, error and retired-step count; sits between the program ROM and the FPGA result checker.

---
 rtl/zero_exec_pkg.sv | 30 +++
 rtl/zero_out_fifo.sv | 67 ++++++
 rtl/zero_arith_exec.sv | 250 +++++++++++++++++++++++++
 tb/tb_zero_arith_exec.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zero_exec_pkg.sv
// Shared types and width helpers for the Zero test-program executor.
package zero_exec_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MOV  = 3'd2,
      OP_OUT  = 3'd3,
      OP_HALT = 3'd7
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_OUT_WAIT,
      ST_DONE
   } state_t;

   localparam int OP_W = 3;

   function automatic int data_field_w(input int w);
      return w + 1;
   endfunction

   function automatic int instr_width(input int w, input int law);
      return OP_W + law + 2 * data_field_w(w);
   endfunction

endpackage

// File: rtl/zero_out_fifo.sv
// First-word-fall-through result FIFO; depth NOut must be a power of two.
module zero_out_fifo #(
   parameter int W    = 12,
   parameter int NOut = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         full,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   localparam int PW = $clog2(NOut);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [NOut];
   logic [W-1:0]  mem_d [NOut];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign out_valid = (cnt_q != '0);
   assign full      = (cnt_q == CW'(NOut));
   assign out_data  = mem_q[rd_q];
   assign do_push   = push && !full;
   assign do_pop    = out_valid && out_ready;

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (clear) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + PW'(1);
         end
         cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q <= '{default: '0};
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/zero_arith_exec.sv
// Clocked executor for generated Zero programs fetched from a synchronous ROM.
// Optional retire trace outputs are enabled with ZERO_ARITH_EXEC_TRACE_EN.
//
// state     | meaning
// IDLE      | waiting for start after reset
// FETCH     | instr_addr presented, ROM data arrives next cycle
// EXEC      | decode and execute the fetched instruction
// OUT_WAIT  | OUT stalled on a full FIFO
// DONE      | halted, failed or timed out; FIFO keeps draining
module zero_arith_exec
   import zero_exec_pkg::*;
#(
   parameter int MemoryElementWidth = 12,
   parameter int NLocal             = 8,
   parameter int NOut               = 4,
   parameter int IpWidth            = 8,
   parameter int MaxSteps           = 1000
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   output logic [IpWidth-1:0]            instr_addr,
   input  logic [instr_width(MemoryElementWidth, $clog2(NLocal))-1:0] instr_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MemoryElementWidth-1:0] out_data,
   output logic                          busy,
   output logic                          finished,
   output logic                          error,
   output logic [31:0]                   steps
`ifdef ZERO_ARITH_EXEC_TRACE_EN
   ,
   output logic                          trace_valid,
   output logic [IpWidth-1:0]            trace_ip,
   output logic [2:0]                    trace_op,
   output logic [MemoryElementWidth-1:0] trace_value
`endif
);

   localparam int W   = MemoryElementWidth;
   localparam int LAW = $clog2(NLocal);

   typedef struct packed {
      logic [2:0]     op;
      logic [LAW-1:0] dst;
      logic           a_imm;
      logic [W-1:0]   a;
      logic           b_imm;
      logic [W-1:0]   b;
   } instr_t;

   instr_t ins;
   assign ins = instr_t'(instr_data);

   state_t         state_q, state_d;
   logic [IpWidth-1:0] ip_q, ip_d;
   logic [31:0]    steps_q, steps_d;
   logic           finished_q, finished_d;
   logic           error_q, error_d;
   logic [W-1:0]   pend_q, pend_d;
   logic [W-1:0]   mem_q [NLocal];
   logic [W-1:0]   mem_d [NLocal];

   logic           fifo_clr, fifo_push, fifo_full;
   logic [W-1:0]   fifo_wdata;
   logic [W-1:0]   a_val, b_val;
   logic           retire, is_halt;
   logic [W-1:0]   ret_val;
   logic [2:0]     ret_op;

   assign a_val = ins.a_imm ? ins.a : mem_q[ins.a[LAW-1:0]];
   assign b_val = ins.b_imm ? ins.b : mem_q[ins.b[LAW-1:0]];

   always_comb begin
      state_d    = state_q;
      ip_d       = ip_q;
      steps_d    = steps_q;
      finished_d = finished_q;
      error_d    = error_q;
      pend_d     = pend_q;
      mem_d      = mem_q;
      fifo_clr   = 1'b0;
      fifo_push  = 1'b0;
      fifo_wdata = pend_q;
      retire     = 1'b0;
      is_halt    = 1'b0;
      ret_val    = '0;
      ret_op     = ins.op;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               ip_d       = '0;
               steps_d    = '0;
               finished_d = 1'b0;
               error_d    = 1'b0;
               fifo_clr   = 1'b1;
               state_d    = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            case (ins.op)
               OP_ADD: begin
                  ret_val        = a_val + b_val;
                  mem_d[ins.dst] = ret_val;
                  retire         = 1'b1;
               end
               OP_SUB: begin
                  ret_val        = a_val - b_val;
                  mem_d[ins.dst] = ret_val;
                  retire         = 1'b1;
               end
               OP_MOV: begin
                  ret_val        = a_val;
                  mem_d[ins.dst] = ret_val;
                  retire         = 1'b1;
               end
               OP_OUT: begin
                  pend_d = a_val;
                  if (!fifo_full) begin
                     fifo_push  = 1'b1;
                     fifo_wdata = a_val;
                     ret_val    = a_val;
                     retire     = 1'b1;
                  end else begin
                     state_d = ST_OUT_WAIT;
                  end
               end
               OP_HALT: begin
                  retire  = 1'b1;
                  is_halt = 1'b1;
               end
               default: begin
                  error_d    = 1'b1;
                  finished_d = 1'b1;
                  state_d    = ST_DONE;
               end
            endcase
         end
         ST_OUT_WAIT: begin
            ret_op = OP_OUT;
            if (!fifo_full) begin
               fifo_push = 1'b1;
               ret_val   = pend_q;
               retire    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // HALT is retired and counted, but only non-HALT retires can time out
      if (retire) begin
         steps_d = steps_q + 32'd1;
         ip_d    = ip_q + IpWidth'(1);
         if (is_halt) begin
            finished_d = 1'b1;
            state_d    = ST_DONE;
         end else if (steps_d == 32'(MaxSteps)) begin
            finished_d = 1'b1;
            error_d    = 1'b1;
            state_d    = ST_DONE;
         end else begin
            state_d = ST_FETCH;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         ip_q       <= '0;
         steps_q    <= '0;
         finished_q <= 1'b0;
         error_q    <= 1'b0;
         pend_q     <= '0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         ip_q       <= ip_d;
         steps_q    <= steps_d;
         finished_q <= finished_d;
         error_q    <= error_d;
         pend_q     <= pend_d;
         mem_q      <= mem_d;
      end
   end

   zero_out_fifo #(
      .W    (W),
      .NOut (NOut)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (fifo_clr),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .full      (fifo_full),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   assign instr_addr = ip_q;
   assign busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_OUT_WAIT);
   assign finished   = finished_q;
   assign error      = error_q;
   assign steps      = steps_q;

`ifdef ZERO_ARITH_EXEC_TRACE_EN
   logic               trace_valid_q, trace_valid_d;
   logic [IpWidth-1:0] trace_ip_q, trace_ip_d;
   logic [2:0]         trace_op_q, trace_op_d;
   logic [W-1:0]       trace_value_q, trace_value_d;

   always_comb begin
      trace_valid_d = retire;
      trace_ip_d    = trace_ip_q;
      trace_op_d    = trace_op_q;
      trace_value_d = trace_value_q;
      if (retire) begin
         trace_ip_d    = ip_q;
         trace_op_d    = ret_op;
         trace_value_d = ret_val;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         trace_valid_q <= 1'b0;
         trace_ip_q    <= '0;
         trace_op_q    <= '0;
         trace_value_q <= '0;
      end else begin
         trace_valid_q <= trace_valid_d;
         trace_ip_q    <= trace_ip_d;
         trace_op_q    <= trace_op_d;
         trace_value_q <= trace_value_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_ip    = trace_ip_q;
   assign trace_op    = trace_op_q;
   assign trace_value = trace_value_q;
`else
   logic unused_trace;
   assign unused_trace = ^{ret_val, ret_op};
`endif

endmodule

// File: tb/tb_zero_arith_exec.sv
// Bench for zero_arith_exec: directed programs plus random programs checked against an interpreter.
module tb_zero_arith_exec;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  instr_addr;
   logic [31:0] instr_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] out_data;
   logic        busy, finished, error;
   logic [31:0] steps;
`ifdef ZERO_ARITH_EXEC_TRACE_EN
   logic        trace_valid;
   logic [7:0]  trace_ip;
   logic [2:0]  trace_op;
   logic [11:0] trace_value;
`endif

   zero_arith_exec #(
      .MemoryElementWidth (12),
      .NLocal             (8),
      .NOut               (4),
      .IpWidth            (8),
      .MaxSteps           (1000)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .instr_addr (instr_addr),
      .instr_data (instr_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .finished   (finished),
      .error      (error),
      .steps      (steps)
`ifdef ZERO_ARITH_EXEC_TRACE_EN
      ,
      .trace_valid (trace_valid),
      .trace_ip    (trace_ip),
      .trace_op    (trace_op),
      .trace_value (trace_value)
`endif
   );

   always #5 clock = ~clock;

   logic [31:0] rom [256];
   always @(posedge clock) instr_data <= rom[instr_addr];

   int checks = 0;
   int failures = 0;
   int ready_mode = 1;        // 0 hold low, 1 hold high, 2 random
   int got [$];
   int exp_q [$];
   int m_mem [8];
   int m_steps, m_err, m_fin, m_ip;

   // Pops happen at the next rising edge when valid and ready are both high.
   always @(negedge clock) begin
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset_n && out_valid && out_ready) got.push_back(int'(out_data));
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] enc(input int op, input int dst, input int ai, input int a,
                                       input int bi, input int b);
      logic [2:0]  o, d;
      logic        ia, ib;
      logic [11:0] av, bv;
      o  = 3'(op);
      d  = 3'(dst);
      ia = 1'(ai);
      ib = 1'(bi);
      av = 12'(a);
      bv = 12'(b);
      return {o, d, ia, av, ib, bv};
   endfunction

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) rom[i] = enc(7, 0, 0, 0, 0, 0);
   endtask

   // Straightforward interpreter of the program in rom[] over the bench's copy of local memory.
   task automatic model_run();
      int ip, op, av, bv, res;
      bit stop;
      logic [31:0] w;
      exp_q.delete();
      m_steps = 0; m_err = 0; m_fin = 0; ip = 0; stop = 0;
      while (!stop) begin
         w   = rom[ip];
         op  = int'(w[31:29]);
         av  = w[25] ? int'(w[24:13]) : m_mem[w[15:13]];
         bv  = w[12] ? int'(w[11:0])  : m_mem[w[2:0]];
         res = 0;
         if (op >= 4 && op <= 6) begin
            m_err = 1; m_fin = 1; stop = 1;
         end else begin
            case (op)
               0: m_mem[w[28:26]] = (av + bv) % 4096;
               1: m_mem[w[28:26]] = (av - bv + 4096) % 4096;
               2: m_mem[w[28:26]] = av;
               3: exp_q.push_back(av);
               default: res = 1;
            endcase
            m_steps++;
            ip = (ip + 1) % 256;
            if (res == 1) begin
               m_fin = 1; stop = 1;
            end else if (m_steps == 1000) begin
               m_err = 1; m_fin = 1; stop = 1;
            end
         end
      end
      m_ip = ip;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output int cyc);
      int d;
      cyc = 0;
      while (!finished && cyc < max_cyc) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      check_val("done_in_budget", 64'(finished), 64'd1);
      d = 0;
      while ((got.size() < exp_q.size() || out_valid) && d < 300) begin
         @(posedge clock);
         #1;
         d++;
      end
   endtask

   task automatic compare_run(input string tag);
      check_val({tag, "_steps"}, 64'(steps), 64'(m_steps));
      check_val({tag, "_error"}, 64'(error), 64'(m_err));
      check_val({tag, "_finished"}, 64'(finished), 64'(m_fin));
      check_val({tag, "_busy"}, 64'(busy), 64'd0);
      check_val({tag, "_ip"}, 64'(instr_addr), 64'(m_ip));
      check_val({tag, "_nout"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check_val($sformatf("%s_out%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
   endtask

   task automatic run_prog(input string tag, input int mode, input int max_cyc, output int cyc);
      model_run();
      got.delete();
      ready_mode = mode;
      pulse_start();
      wait_done(max_cyc, cyc);
      compare_run(tag);
   endtask

   initial begin
      int cyc, extra, n;
      #900000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, n;
      fill_halt();
      for (int i = 0; i < 8; i++) m_mem[i] = 0;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_finished", 64'(finished), 64'd0);
      check_val("rst_error", 64'(error), 64'd0);
      check_val("rst_steps", 64'(steps), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_instr_addr", 64'(instr_addr), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // SUB l0 = 4-2, OUT l0, HALT
      fill_halt();
      rom[0] = enc(1, 0, 1, 4, 1, 2);
      rom[1] = enc(3, 0, 0, 0, 0, 0);
      rom[2] = enc(7, 0, 0, 0, 0, 0);
      run_prog("basic", 1, 100, cyc);
      check_val("basic_cycles", 64'(cyc), 64'd6);
      check_val("basic_value", 64'(got.size() > 0 ? got[0] : -1), 64'd2);

      // Wrapping subtraction and addition
      fill_halt();
      rom[0] = enc(1, 1, 1, 2, 1, 4);
      rom[1] = enc(3, 0, 0, 1, 0, 0);
      rom[2] = enc(0, 2, 1, 4095, 1, 3);
      rom[3] = enc(3, 0, 0, 2, 0, 0);
      run_prog("wrap", 2, 200, cyc);
      check_val("wrap_sub_value", 64'(got.size() > 0 ? got[0] : -1), 64'd4094);
      check_val("wrap_add_value", 64'(got.size() > 1 ? got[1] : -1), 64'd2);

      // Six OUTs with a blocked consumer, then release
      fill_halt();
      for (int i = 0; i < 6; i++) rom[i] = enc(3, 0, 1, i + 1, 0, 0);
      model_run();
      got.delete();
      ready_mode = 0;
      pulse_start();
      repeat (40) @(posedge clock);
      #1;
      check_val("stall_busy", 64'(busy), 64'd1);
      check_val("stall_finished", 64'(finished), 64'd0);
      check_val("stall_steps", 64'(steps), 64'd4);
      check_val("stall_valid", 64'(out_valid), 64'd1);
      check_val("stall_no_pop", 64'(got.size()), 64'd0);
      ready_mode = 1;
      wait_done(200, cyc);
      compare_run("stall");

      // Illegal opcode at ip 2 with an ignored start mid-run
      fill_halt();
      rom[0] = enc(2, 4, 1, 11, 0, 0);
      rom[1] = enc(2, 5, 0, 4, 0, 0);
      rom[2] = enc(5, 0, 0, 0, 0, 0);
      rom[3] = enc(3, 0, 1, 99, 0, 0);
      model_run();
      got.delete();
      ready_mode = 1;
      pulse_start();
      @(posedge clock); #1;
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(100, cyc);
      check_val("illegal_cycles", 64'(cyc + 3), 64'd6);
      compare_run("illegal");

      // Random programs against the interpreter
      for (int t = 0; t < 20; t++) begin
         fill_halt();
         n = $urandom_range(3, 14);
         for (int i = 0; i < n; i++)
            rom[i] = enc($urandom_range(0, 3), $urandom_range(0, 7),
                         $urandom_range(0, 1), $urandom_range(0, 4095),
                         $urandom_range(0, 1), $urandom_range(0, 4095));
         run_prog($sformatf("rand%0d", t), 2, 400, cyc);
      end

      // No HALT: timeout after MaxSteps, ip wraps past 255
      for (int i = 0; i < 256; i++) rom[i] = enc(2, i % 8, 1, i, 0, 0);
      run_prog("timeout", 1, 2200, cyc);

      // Reset while stalled in OUT_WAIT
      fill_halt();
      for (int i = 0; i < 6; i++) rom[i] = enc(3, 0, 1, 9, 0, 0);
      got.delete();
      ready_mode = 0;
      pulse_start();
      repeat (30) @(posedge clock);
      #1;
      check_val("prerst_busy", 64'(busy), 64'd1);
      #2;
      reset_n = 1'b0;
      for (int i = 0; i < 8; i++) m_mem[i] = 0;
      #1;
      check_val("midrst_busy", 64'(busy), 64'd0);
      check_val("midrst_valid", 64'(out_valid), 64'd0);
      check_val("midrst_data", 64'(out_data), 64'd0);
      check_val("midrst_steps", 64'(steps), 64'd0);
      check_val("midrst_addr", 64'(instr_addr), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      fill_halt();
      rom[0] = enc(3, 0, 0, 3, 0, 0);
      rom[1] = enc(2, 3, 1, 7, 0, 0);
      rom[2] = enc(3, 0, 0, 3, 0, 0);
      run_prog("after_rst", 2, 200, cyc);
      check_val("after_rst_zero", 64'(got.size() > 0 ? got[0] : -1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
